// File: rtl/rv_pkg.sv
`default_nettype none
// ==========================================================================
// rv_pkg : shared RV32I funct3 codes and LSU state type      Rev 1.0
// ==========================================================================
package rv_pkg;

    localparam logic [2:0] C_F3_LB  = 3'b000;
    localparam logic [2:0] C_F3_LH  = 3'b001;
    localparam logic [2:0] C_F3_LW  = 3'b010;
    localparam logic [2:0] C_F3_LBU = 3'b100;
    localparam logic [2:0] C_F3_LHU = 3'b101;
    localparam logic [2:0] C_F3_SB  = 3'b000;
    localparam logic [2:0] C_F3_SH  = 3'b001;
    localparam logic [2:0] C_F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUS  = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_e;

    // Misaligned or unencodable accesses never reach the bus.
    function automatic logic lsu_illegal(input logic       we,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
        logic w_bad_f3;
        logic w_misal;
        if (we)
            w_bad_f3 = (funct3 > C_F3_SW);
        else
            w_bad_f3 = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        w_misal = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                  ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
        return w_bad_f3 || w_misal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_lsu_if.sv
`default_nettype none
// ==========================================================================
// rv_lsu_if : Wishbone classic bus between the LSU and memory  Rev 1.0
// ==========================================================================
interface rv_lsu_if;

    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [31:0] i_wb_dat;
    logic        o_wb_we;
    logic [3:0]  o_wb_sel;
    logic        o_wb_stb;
    logic        i_wb_ack;
    logic        o_wb_cyc;

    modport master (
        output o_wb_adr, o_wb_dat, o_wb_we, o_wb_sel, o_wb_stb, o_wb_cyc,
        input  i_wb_dat, i_wb_ack
    );

    modport slave (
        input  o_wb_adr, o_wb_dat, o_wb_we, o_wb_sel, o_wb_stb, o_wb_cyc,
        output i_wb_dat, i_wb_ack
    );

endinterface
`default_nettype wire

// File: rtl/rv_lsu_align.sv
`default_nettype none
// ==========================================================================
// rv_lsu_align : byte-lane select, store replication, load extension Rev 1.0
// ==========================================================================
module rv_lsu_align
    import rv_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_addr_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdat_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_addr_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        sel_o  = 4'b1111;
        wdat_o = st_wdata_i;
        case (st_size_i)
            2'b00: begin
                sel_o  = 4'b0001 << st_addr_i;
                wdat_o = {4{st_wdata_i[7:0]}};
            end
            2'b01: begin
                sel_o  = st_addr_i[1] ? 4'b1100 : 4'b0011;
                wdat_o = {2{st_wdata_i[15:0]}};
            end
            default: begin
                sel_o  = 4'b1111;
                wdat_o = st_wdata_i;
            end
        endcase
    end

    always_comb begin
        w_byte = ld_rdata_i[7:0];
        case (ld_addr_i)
            2'b00:   w_byte = ld_rdata_i[7:0];
            2'b01:   w_byte = ld_rdata_i[15:8];
            2'b10:   w_byte = ld_rdata_i[23:16];
            default: w_byte = ld_rdata_i[31:24];
        endcase
        w_half = ld_addr_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];

        case (ld_funct3_i)
            C_F3_LB:  ld_data_o = {{24{w_byte[7]}}, w_byte};
            C_F3_LH:  ld_data_o = {{16{w_half[15]}}, w_half};
            C_F3_LBU: ld_data_o = {24'h0, w_byte};
            C_F3_LHU: ld_data_o = {16'h0, w_half};
            default:  ld_data_o = ld_rdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv_lsu.sv
`default_nettype none
// ==========================================================================
// rv_lsu : RV32I load/store unit, Wishbone classic master      Rev 1.0
// ==========================================================================
module rv_lsu
    import rv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_err,
    rv_lsu_if.master    wb
);

    localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  alo_q, alo_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;

    logic        w_illegal;
    logic [3:0]  w_sel;
    logic [31:0] w_wdat;
    logic [31:0] w_ld_data;

    rv_lsu_align u_align (
        .st_size_i   (i_funct3[1:0]),
        .st_addr_i   (i_addr[1:0]),
        .st_wdata_i  (i_wdata),
        .sel_o       (w_sel),
        .wdat_o      (w_wdat),
        .ld_funct3_i (funct3_q),
        .ld_addr_i   (alo_q),
        .ld_rdata_i  (wb.i_wb_dat),
        .ld_data_o   (w_ld_data)
    );

    assign w_illegal = lsu_illegal(i_we, i_funct3, i_addr[1:0]);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        we_d       = we_q;
        cyc_d      = cyc_q;
        funct3_d   = funct3_q;
        alo_d      = alo_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            LSU_IDLE: begin
                if (i_req_valid) begin
                    funct3_d   = i_funct3;
                    alo_d      = i_addr[1:0];
                    rsp_data_d = 32'h0;
                    rsp_err_d  = w_illegal;
                    if (w_illegal) begin
                        state_d = LSU_RESP;
                    end else begin
                        state_d = LSU_BUS;
                        cnt_d   = 8'h0;
                        cyc_d   = 1'b1;
                        adr_d   = {i_addr[31:2], 2'b00};
                        we_d    = i_we;
                        sel_d   = w_sel;
                        dat_d   = w_wdat;
                    end
                end
            end
            LSU_BUS: begin
                // cnt_q counts completed BUS cycles, so this cycle is number cnt_q+1.
                if (wb.i_wb_ack) begin
                    cyc_d      = 1'b0;
                    rsp_data_d = w_ld_data;
                    rsp_err_d  = 1'b0;
                    state_d    = LSU_RESP;
                end else if (cnt_q == C_TO_LAST) begin
                    cyc_d      = 1'b0;
                    rsp_data_d = 32'h0;
                    rsp_err_d  = 1'b1;
                    state_d    = LSU_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            LSU_RESP: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q    <= LSU_IDLE;
            cnt_q      <= 8'h0;
            adr_q      <= 32'h0;
            dat_q      <= 32'h0;
            sel_q      <= 4'b0000;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            funct3_q   <= 3'b000;
            alo_q      <= 2'b00;
            rsp_data_q <= 32'h0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            cyc_q      <= cyc_d;
            funct3_q   <= funct3_d;
            alo_q      <= alo_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign o_req_ready  = (state_q == LSU_IDLE);
    assign o_rsp_valid  = (state_q == LSU_RESP);
    assign o_rsp_data   = rsp_data_q;
    assign o_rsp_err    = rsp_err_q;

    // Classic single access: strobe and cycle are the same registered signal.
    assign wb.o_wb_cyc  = cyc_q;
    assign wb.o_wb_stb  = cyc_q;
    assign wb.o_wb_adr  = adr_q;
    assign wb.o_wb_dat  = dat_q;
    assign wb.o_wb_sel  = sel_q;
    assign wb.o_wb_we   = we_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_lsu.sv
`default_nettype none
// ==========================================================================
// tb_rv_lsu : scoreboard bench for rv_lsu with a Wishbone slave model Rev 1.0
// ==========================================================================
`timescale 1ns/1ps
module tb_rv_lsu;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [2:0]  f3;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        ack_s;
    logic        ack_spur;
    logic [31:0] rdat_s;

    always #5 clk = ~clk;

    rv_lsu_if wb();
    assign wb.i_wb_ack = ack_s | ack_spur;
    assign wb.i_wb_dat = rdat_s;

    rv_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .i_we        (we),
        .i_funct3    (f3),
        .o_rsp_valid (rsp_valid),
        .o_rsp_data  (rsp_data),
        .o_rsp_err   (rsp_err),
        .wb          (wb)
    );

    // dly >= 0: ack after dly wait cycles; -1: never ack (timeout);
    // -2: aborted by reset (no response); -3: illegal, no bus cycle.
    typedef struct {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dat;
        int          dly;
        logic [31:0] rd;
    } bus_t;

    // kind 0: error latency check, 1: ack latency check, 2: no latency check
    typedef struct {
        logic        err;
        logic [31:0] data;
        int          kind;
        int          t;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc_cnt = 0;
    int   last_ack = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc_cnt);
        end
    endtask

    task automatic slave();
        bus_t e;
        int   n;
        forever begin
            @(negedge clk);
            if (wb.o_wb_cyc || wb.o_wb_stb) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_bus_cycle", 32'd1, 32'd0);
                    n = 0;
                    while (wb.o_wb_cyc && n < 50) begin @(negedge clk); n++; end
                end else begin
                    e = bus_q.pop_front();
                    chk("wb_cyc_stb", {wb.o_wb_cyc, wb.o_wb_stb}, 32'd3);
                    chk("wb_adr", wb.o_wb_adr, e.adr);
                    chk("wb_sel", wb.o_wb_sel, e.sel);
                    chk("wb_we", wb.o_wb_we, e.we);
                    if (e.we) chk("wb_dat", wb.o_wb_dat, e.dat);
                    if (e.dly >= 0) begin
                        repeat (e.dly) @(negedge clk);
                        rdat_s   = e.rd;
                        ack_s    = 1'b1;
                        last_ack = cyc_cnt + 1;
                        @(negedge clk);
                        ack_s  = 1'b0;
                        rdat_s = 32'h0;
                        chk("wb_drop_on_ack", {wb.o_wb_cyc, wb.o_wb_stb}, 32'd0);
                    end else begin
                        n = 1;
                        while (n < 20) begin
                            @(negedge clk);
                            if (!wb.o_wb_cyc) break;
                            n++;
                        end
                        if (e.dly == -1) chk("timeout_stb_cycles", n, 32'd4);
                    end
                end
            end
        end
    endtask

    task automatic monitor();
        rsp_t e;
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (prev) chk("rsp_single_pulse", 32'd1, 32'd0);
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_err", rsp_err, e.err);
                    chk("rsp_data", rsp_data, e.data);
                    if (e.kind == 0) chk("err_latency", cyc_cnt, e.t);
                    else if (e.kind == 1) chk("ack_latency", cyc_cnt, last_ack);
                end
            end
            prev = rsp_valid;
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic w,
                         input logic [2:0] f, input int dly, input logic [31:0] rd,
                         input logic [3:0] esel, input logic [31:0] edat,
                         input logic eerr, input logic [31:0] edata);
        int   n = 0;
        bus_t b;
        rsp_t r;
        @(negedge clk);
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) begin
            chk("req_ready_wait", 32'd0, 32'd1);
            return;
        end
        addr = a; wdata = wd; we = w; f3 = f; req_valid = 1'b1;
        if (dly != -3) begin
            b.adr = {a[31:2], 2'b00}; b.sel = esel; b.we = w; b.dat = edat;
            b.dly = dly; b.rd = rd;
            bus_q.push_back(b);
        end
        if (dly != -2) begin
            r.err  = eerr;
            r.data = edata;
            r.kind = (dly == -3) ? 0 : ((dly >= 0) ? 1 : 2);
            r.t    = cyc_cnt + 1;
            rsp_q.push_back(r);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; addr = 32'h0; wdata = 32'h0; we = 1'b0; f3 = 3'b000;
        ack_s = 1'b0; ack_spur = 1'b0; rdat_s = 32'h0;
        fork
            slave();
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 32'd1);
        chk("rst_cyc_stb_we", {wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_we}, 32'd0);
        chk("rst_sel", wb.o_wb_sel, 32'd0);
        chk("rst_adr", wb.o_wb_adr, 32'd0);
        chk("rst_dat", wb.o_wb_dat, 32'd0);
        chk("rst_rsp", {rsp_valid, rsp_err}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        reset_n = 1'b1;

        //    addr          wdata         we    f3        dly rd            sel      dat           err   data
        issue(32'h100, 32'hDEADBEEF, 1'b1, C_F3_SW,  2, 32'h0,        4'b1111, 32'hDEADBEEF, 1'b0, 32'h0);
        issue(32'h103, 32'h0,        1'b0, C_F3_LB,  0, 32'h80FF1234, 4'b1000, 32'h0,        1'b0, 32'hFFFFFF80);
        issue(32'h103, 32'h0,        1'b0, C_F3_LBU, 1, 32'h80FF1234, 4'b1000, 32'h0,        1'b0, 32'h00000080);
        issue(32'h202, 32'h0000ABCD, 1'b1, C_F3_SH,  0, 32'h0,        4'b1100, 32'hABCDABCD, 1'b0, 32'h0);
        issue(32'h202, 32'h0,        1'b0, C_F3_LHU, 0, 32'hABCD0000, 4'b1100, 32'h0,        1'b0, 32'h0000ABCD);
        issue(32'h200, 32'h0,        1'b0, C_F3_LH,  1, 32'h12348001, 4'b0011, 32'h0,        1'b0, 32'hFFFF8001);
        issue(32'h104, 32'h0,        1'b0, C_F3_LW,  3, 32'h12345678, 4'b1111, 32'h0,        1'b0, 32'h12345678);
        issue(32'h301, 32'h1234565A, 1'b1, C_F3_SB,  0, 32'h0,        4'b0010, 32'h5A5A5A5A, 1'b0, 32'h0);
        issue(32'h101, 32'h0,        1'b0, C_F3_LW, -3, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h0);
        issue(32'h203, 32'h0,        1'b0, C_F3_LH, -3, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h0);
        issue(32'h102, 32'h11223344, 1'b1, C_F3_SW, -3, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h0);
        issue(32'h000, 32'h0,        1'b0, 3'b011,  -3, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h0);
        issue(32'h000, 32'h0,        1'b1, 3'b011,  -3, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h0);
        issue(32'h000, 32'h0,        1'b0, 3'b110,  -3, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h0);
        issue(32'h400, 32'h0,        1'b0, C_F3_LW, -1, 32'h0,        4'b1111, 32'h0,        1'b1, 32'h0);

        // Ack arriving while idle must not start or finish anything.
        repeat (6) @(negedge clk);
        ack_spur = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("spur_ack_no_cyc", {wb.o_wb_cyc, wb.o_wb_stb}, 32'd0);
            chk("spur_ack_ready", req_ready, 32'd1);
        end
        ack_spur = 1'b0;

        issue(32'h500, 32'hCAFEF00D, 1'b1, C_F3_SW, -2, 32'h0,        4'b1111, 32'hCAFEF00D, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_cyc_stb", {wb.o_wb_cyc, wb.o_wb_stb}, 32'd0);
        chk("abort_sel", wb.o_wb_sel, 32'd0);
        chk("abort_adr", wb.o_wb_adr, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("abort_ready_after", req_ready, 32'd1);

        issue(32'h501, 32'h0,        1'b0, C_F3_LBU, 0, 32'h0000C300, 4'b0010, 32'h0,        1'b0, 32'h000000C3);

        repeat (8) @(negedge clk);
        chk("rsp_queue_drained", rsp_q.size(), 32'd0);
        chk("bus_queue_drained", bus_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
